// File: rtl/wrr_pkt_scheduler_if.sv
// Channel request/weight/length bundle, formatter handshake and scheduler results
// shared between the packet scheduler and whatever drives it.
interface wrr_pkt_scheduler_if #(
  parameter int CRED_W = 8,
  parameter int WGT_W  = 4
);
  logic              slv0_req_i;
  logic              slv1_req_i;
  logic              slv2_req_i;
  logic [WGT_W-1:0]  slv0_weight_i;
  logic [WGT_W-1:0]  slv1_weight_i;
  logic [WGT_W-1:0]  slv2_weight_i;
  logic [2:0]        slv0_pkglen_i;
  logic [2:0]        slv1_pkglen_i;
  logic [2:0]        slv2_pkglen_i;
  logic              f2a_id_req_i;
  logic              pkt_done_i;
  logic [2:0]        sched_grant_o;
  logic [1:0]        sched_id_o;
  logic [5:0]        sched_len_o;
  logic              sched_busy_o;
  logic [CRED_W-1:0] slv0_credit_o;
  logic [CRED_W-1:0] slv1_credit_o;
  logic [CRED_W-1:0] slv2_credit_o;

  modport slave (
    input  slv0_req_i, slv1_req_i, slv2_req_i,
    input  slv0_weight_i, slv1_weight_i, slv2_weight_i,
    input  slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
    input  f2a_id_req_i, pkt_done_i,
    output sched_grant_o, sched_id_o, sched_len_o, sched_busy_o,
    output slv0_credit_o, slv1_credit_o, slv2_credit_o
  );

  modport master (
    output slv0_req_i, slv1_req_i, slv2_req_i,
    output slv0_weight_i, slv1_weight_i, slv2_weight_i,
    output slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
    output f2a_id_req_i, pkt_done_i,
    input  sched_grant_o, sched_id_o, sched_len_o, sched_busy_o,
    input  slv0_credit_o, slv1_credit_o, slv2_credit_o
  );
endinterface

// File: rtl/wrr_pkt_scheduler.sv
// Deficit weighted round-robin packet scheduler over three FIFO channels: one
// complete packet at a time, metered by saturating per-channel word credits.
module wrr_pkt_scheduler #(
  parameter int CRED_W = 8,
  parameter int WGT_W  = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  wrr_pkt_scheduler_if.slave   bus
);
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SELECT    = 2'd1;
  localparam logic [1:0] ST_GRANT     = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  function automatic logic [5:0] len_dec(input logic [2:0] code);
    logic [5:0] len;
    case (code)
      3'd0:    len = 6'd4;
      3'd1:    len = 6'd8;
      3'd2:    len = 6'd16;
      default: len = 6'd32;
    endcase
    return len;
  endfunction

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] r;
    if (v >= 3'd3) begin
      r = v - 3'd3;
    end else begin
      r = v;
    end
    return r[1:0];
  endfunction

  logic [1:0]                   state_r;
  logic [1:0]                   ptr_r;
  logic [2:0]                   grant_r;
  logic [1:0]                   id_r;
  logic [5:0]                   len_r;
  logic                         busy_r;
  logic [2:0][CRED_W-1:0]       credit_r;

  logic [2:0]                   req_s;
  logic [2:0]                   wnz_s;
  logic [2:0][WGT_W-1:0]        wgt_s;
  logic [2:0][5:0]              len_s;
  logic [2:0]                   elig_s;
  logic                         any_active_s;
  logic [2:0][CRED_W:0]         sum_s;
  logic [2:0][CRED_W-1:0]       repl_s;
  logic                         found_s;
  logic [1:0]                   win_s;
  logic [1:0]                   idx_s;

  assign req_s = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
  assign wgt_s = {bus.slv2_weight_i, bus.slv1_weight_i, bus.slv0_weight_i};
  assign len_s = {len_dec(bus.slv2_pkglen_i), len_dec(bus.slv1_pkglen_i),
                  len_dec(bus.slv0_pkglen_i)};

  // Per-channel eligibility and the replenished credit each channel would take
  always_comb begin
    wnz_s  = 3'b000;
    elig_s = 3'b000;
    sum_s  = '{default: {(CRED_W+1){1'b0}}};
    repl_s = '{default: {CRED_W{1'b0}}};
    for (int n = 0; n < 3; n++) begin
      wnz_s[n]  = (wgt_s[n] != {WGT_W{1'b0}});
      elig_s[n] = req_s[n] && wnz_s[n] &&
                  (credit_r[n] >= {{(CRED_W-6){1'b0}}, len_s[n]});
      sum_s[n]  = {1'b0, credit_r[n]} + {{(CRED_W-1-WGT_W){1'b0}}, wgt_s[n], 2'b00};
      if (req_s[n] && wnz_s[n]) begin
        if (sum_s[n][CRED_W]) begin
          repl_s[n] = {CRED_W{1'b1}};
        end else begin
          repl_s[n] = sum_s[n][CRED_W-1:0];
        end
      end else begin
        repl_s[n] = {CRED_W{1'b0}};
      end
    end
  end

  assign any_active_s = |(req_s & wnz_s);

  // Round-robin scan starting at the pointer; first eligible channel wins
  always_comb begin
    found_s = 1'b0;
    win_s   = 2'd0;
    idx_s   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx_s = wrap3({1'b0, ptr_r} + 3'(k));
      if (!found_s && elig_s[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Scheduler FSM with registered grant/ID/length/busy and credit bookkeeping
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r  <= ST_IDLE;
      ptr_r    <= 2'd0;
      grant_r  <= 3'b000;
      id_r     <= 2'd0;
      len_r    <= 6'd0;
      busy_r   <= 1'b0;
      credit_r <= '{default: {CRED_W{1'b0}}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          grant_r <= 3'b000;
          if (bus.f2a_id_req_i && any_active_s) begin
            state_r <= ST_SELECT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SELECT: begin
          if (found_s) begin
            id_r    <= win_s;
            len_r   <= len_s[win_s];
            grant_r <= 3'b001 << win_s;
            busy_r  <= 1'b1;
            state_r <= ST_GRANT;
          end else if (any_active_s) begin
            credit_r <= repl_s;
            state_r  <= ST_SELECT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          credit_r[id_r] <= credit_r[id_r] - {{(CRED_W-6){1'b0}}, len_r};
          ptr_r          <= wrap3({1'b0, id_r} + 3'd1);
          grant_r        <= 3'b000;
          state_r        <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.pkt_done_i) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end
        default: begin
          grant_r <= 3'b000;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sched_grant_o = grant_r;
  assign bus.sched_id_o    = id_r;
  assign bus.sched_len_o   = len_r;
  assign bus.sched_busy_o  = busy_r;
  assign bus.slv0_credit_o = credit_r[0];
  assign bus.slv1_credit_o = credit_r[1];
  assign bus.slv2_credit_o = credit_r[2];
endmodule

// File: tb/tb_wrr_pkt_scheduler.sv
// Directed bench for wrr_pkt_scheduler: hand-computed grant order, lengths,
// replenish latency and credit values across weight/length scenarios.
module tb_wrr_pkt_scheduler;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  logic [23:0] cg;

  wrr_pkt_scheduler_if #(.CRED_W(8), .WGT_W(4)) bus ();

  wrr_pkt_scheduler #(.CRED_W(8), .WGT_W(4)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] req, input logic [3:0] w0, input logic [3:0] w1,
                     input logic [3:0] w2, input logic [2:0] c0, input logic [2:0] c1,
                     input logic [2:0] c2);
    bus.slv0_req_i    = req[0];
    bus.slv1_req_i    = req[1];
    bus.slv2_req_i    = req[2];
    bus.slv0_weight_i = w0;
    bus.slv1_weight_i = w1;
    bus.slv2_weight_i = w2;
    bus.slv0_pkglen_i = c0;
    bus.slv1_pkglen_i = c1;
    bus.slv2_pkglen_i = c2;
  endtask

  function automatic logic [23:0] creds();
    return {bus.slv2_credit_o, bus.slv1_credit_o, bus.slv0_credit_o};
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  // Pulse f2a_id_req, wait (bounded) for the grant, check it, step through GRANT.
  task automatic start_pkt(input logic [1:0] eid, input logic [5:0] elen,
                           input int ewait, output logic [23:0] cred_at_grant);
    int n;
    bus.f2a_id_req_i = 1'b1;
    step();
    bus.f2a_id_req_i = 1'b0;
    n = 0;
    while (bus.sched_grant_o == 3'b000 && n < 30) begin
      step();
      n++;
    end
    chk("select_cycles", n, ewait);
    chk("grant", bus.sched_grant_o, 3'b001 << eid);
    chk("id", bus.sched_id_o, eid);
    chk("len", bus.sched_len_o, elen);
    chk("busy_grant", bus.sched_busy_o, 1'b1);
    cred_at_grant = creds();
    step();
    chk("grant_1cyc", bus.sched_grant_o, 3'b000);
    chk("busy_wait", bus.sched_busy_o, 1'b1);
  endtask

  task automatic finish_pkt();
    bus.pkt_done_i = 1'b1;
    step();
    bus.pkt_done_i = 1'b0;
    chk("busy_done", bus.sched_busy_o, 1'b0);
    chk("grant_done", bus.sched_grant_o, 3'b000);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    bus.f2a_id_req_i = 1'b0;
    bus.pkt_done_i   = 1'b0;
    cfg(3'b000, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0, 3'd0);
    step();
    step();
    chk("rst_grant", bus.sched_grant_o, 3'b000);
    chk("rst_id", bus.sched_id_o, 2'd0);
    chk("rst_len", bus.sched_len_o, 6'd0);
    chk("rst_busy", bus.sched_busy_o, 1'b0);
    chk("rst_cred", creds(), 24'h000000);
    rstn = 1'b1;
    step();

    // Equal weights, length 4: plain round robin, replenish every third packet
    cfg(3'b111, 4'd1, 4'd1, 4'd1, 3'd0, 3'd0, 3'd0);
    start_pkt(2'd0, 6'd4, 2, cg);
    chk("eq_cred_g1", cg, 24'h040404);
    chk("eq_cred1", creds(), 24'h040400);
    finish_pkt();
    start_pkt(2'd1, 6'd4, 1, cg);
    chk("eq_cred2", creds(), 24'h040000);
    finish_pkt();
    start_pkt(2'd2, 6'd4, 1, cg);
    chk("eq_cred3", creds(), 24'h000000);
    finish_pkt();
    start_pkt(2'd0, 6'd4, 2, cg);
    chk("eq_cred4", creds(), 24'h040400);
    finish_pkt();
    start_pkt(2'd1, 6'd4, 1, cg);
    finish_pkt();
    start_pkt(2'd2, 6'd4, 1, cg);
    chk("eq_cred6", creds(), 24'h000000);
    finish_pkt();
    start_pkt(2'd0, 6'd4, 2, cg);

    // Asynchronous reset while the packet is in flight
    rstn = 1'b0;
    #2;
    chk("mid_rst_busy", bus.sched_busy_o, 1'b0);
    chk("mid_rst_grant", bus.sched_grant_o, 3'b000);
    chk("mid_rst_id", bus.sched_id_o, 2'd0);
    chk("mid_rst_len", bus.sched_len_o, 6'd0);
    chk("mid_rst_cred", creds(), 24'h000000);
    step();
    rstn = 1'b1;
    step();

    // Weights 2/1/1: ch0 carries a double quantum, scan restarts at ch0
    cfg(3'b111, 4'd2, 4'd1, 4'd1, 3'd0, 3'd0, 3'd0);
    start_pkt(2'd0, 6'd4, 2, cg);
    chk("w2_cred_g1", cg, 24'h040408);
    chk("w2_cred1", creds(), 24'h040404);
    finish_pkt();
    start_pkt(2'd1, 6'd4, 1, cg);
    chk("w2_cred2", creds(), 24'h040004);
    finish_pkt();
    start_pkt(2'd2, 6'd4, 1, cg);
    chk("w2_cred3", creds(), 24'h000004);
    finish_pkt();
    start_pkt(2'd0, 6'd4, 1, cg);
    chk("w2_cred4", creds(), 24'h000000);
    finish_pkt();
    start_pkt(2'd1, 6'd4, 2, cg);
    chk("w2_cred5", creds(), 24'h040008);
    finish_pkt();
    start_pkt(2'd2, 6'd4, 1, cg);
    chk("w2_cred6", creds(), 24'h000008);
    finish_pkt();

    // Sole requester ch2, weight 1, length 32: eight replenish cycles
    do_reset();
    cfg(3'b100, 4'd1, 4'd1, 4'd1, 3'd3, 3'd3, 3'd3);
    start_pkt(2'd2, 6'd32, 9, cg);
    chk("long_cred_g", cg, 24'h200000);
    chk("long_cred", creds(), 24'h000000);
    finish_pkt();

    // Weight-0 sole requester is never served
    do_reset();
    cfg(3'b010, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0, 3'd0);
    bus.f2a_id_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("w0_grant", bus.sched_grant_o, 3'b000);
    end
    bus.f2a_id_req_i = 1'b0;
    chk("w0_busy", bus.sched_busy_o, 1'b0);
    chk("w0_cred", creds(), 24'h000000);

    // Request vanishes during SELECT: back to IDLE, no later self-start
    cfg(3'b001, 4'd1, 4'd0, 4'd0, 3'd3, 3'd0, 3'd0);
    bus.f2a_id_req_i = 1'b1;
    step();
    bus.f2a_id_req_i = 1'b0;
    bus.slv0_req_i   = 1'b0;
    step();
    bus.slv0_req_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
    end
    chk("drop_grant", bus.sched_grant_o, 3'b000);
    chk("drop_busy", bus.sched_busy_o, 1'b0);
    chk("drop_cred", creds(), 24'h000000);

    // pkt_done in IDLE ignored; request toggling in WAIT_DONE ignored
    do_reset();
    cfg(3'b111, 4'd1, 4'd1, 4'd1, 3'd0, 3'd0, 3'd0);
    bus.pkt_done_i = 1'b1;
    step();
    bus.pkt_done_i = 1'b0;
    step();
    chk("idle_done_busy", bus.sched_busy_o, 1'b0);
    chk("idle_done_grant", bus.sched_grant_o, 3'b000);
    start_pkt(2'd0, 6'd4, 2, cg);
    for (int i = 0; i < 3; i++) begin
      cfg(3'b000, 4'd1, 4'd1, 4'd1, 3'd0, 3'd0, 3'd0);
      step();
      cfg(3'b111, 4'd1, 4'd1, 4'd1, 3'd0, 3'd0, 3'd0);
      step();
      chk("wait_hold_busy", bus.sched_busy_o, 1'b1);
    end
    chk("wait_hold_cred", creds(), 24'h040400);
    finish_pkt();
    start_pkt(2'd1, 6'd4, 1, cg);
    finish_pkt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
